uart_boot_sequencer: RTL and testbench
======================================

# uart_boot_sequencer

Controller that sequences the UART byte stream into instruction-memory writes and hands the loaded program to the CPU pipeline. It sits between the `uart` receiver/transmitter and the instruction memory / CPU `start` input. It consumes received bytes, echoes them, and packs 8 hex characters (MSB nibble first) into 32-bit words written to consecutive addresses. It then gates CPU run/halt with a LOAD → RUN → HALTED state machine.

## Interface

Parameters:
- `DEPTH`, default 16: instruction words; addresses wrap never, saturate at `DEPTH`.
- `ADDR_W`, default 4: `$clog2(DEPTH)`.
- `WORD_W`, default 32: instruction word width; must equal 4 × 8 nibbles.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `rx_data`  in  8  received byte from the UART (`dout`).
- `rx_valid`  in  1  received byte pending (`rdy`).
- `rx_clr`  out  1  one-cycle pulse that consumes the pending byte (`rdy_clr`).
- `tx_data`  out  8  echo byte.
- `tx_wr`  out  1  one-cycle echo write strobe.
- `tx_busy`  in  1  transmitter busy.
- `imem_we`  out  1  one-cycle instruction-memory write enable.
- `imem_addr`  out  ADDR_W  write address.
- `imem_wdata`  out  WORD_W  write data.
- `run_req`  in  1  external start request (level).
- `cpu_halt`  in  1  CPU reached ebreak (level).
- `cpu_run`  out  1  CPU start/enable (level).
- `word_count`  out  ADDR_W+1  words written since entering LOAD.
- `err`  out  1  sticky protocol error.

## Operation

- States: LOAD (reset state), RUN, HALTED.
- Accept condition: `rx_valid && !tx_busy && !rx_clr`. The `!rx_clr` term locks out re-accepting the same byte while the UART clears `rdy`.
- LOAD, on accept:
  - `rx_clr`=1 and `tx_wr`=1 with `tx_data`=`rx_data`; every accepted byte is echoed.
  - If the byte is '0'–'9', 'A'–'F' or 'a'–'f': shift the nibble into `shreg` (new nibble enters at [3:0], prior contents shift left 4) and increment `nib_cnt` (0..7).
  - When the accepted nibble is the 8th (`nib_cnt`==7): `nib_cnt`←0 and a write is scheduled.
  - 0x0D and 0x0A are ignored; the partial word is kept.
  - Any other byte sets `err`, and `nib_cnt`←0 discards the partial word.
- Write:
  - `imem_we`=1 for one cycle with `imem_addr`=`word_count` and `imem_wdata`=the assembled word.
  - `word_count` increments in the same cycle.
  - If `word_count`==DEPTH, the write is suppressed and `err` is set instead.
- LOAD → RUN when `run_req`==1. If `nib_cnt`≠0, the partial word is discarded and `err` is set. `cpu_run`←1.
- RUN:
  - Bytes are accepted (`rx_clr` pulses) and dropped. No echo, no nibble processing.
  - `cpu_halt`==1 → HALTED.
  - `run_req`==0 → LOAD.
- HALTED: `cpu_run` stays 1 so CPU state is held for inspection. Bytes are dropped as in RUN. `run_req`==0 → LOAD.
- Entering LOAD from RUN or HALTED:
  - `cpu_run`←0, `word_count`←0, `nib_cnt`←0.
  - `err` is preserved; it clears only on `rst`.
- Simultaneous `run_req` fall and `cpu_halt` rise in RUN: go to LOAD.
- Simultaneous LOAD accept and `run_req` rise: the byte is processed, then RUN is entered. If that byte completed a word, the write still occurs before `cpu_run` rises.

## Timing

- All outputs are registered.
- Reset values: `rx_clr`=0, `tx_wr`=0, `tx_data`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `cpu_run`=0, `word_count`=0, `err`=0. Internal: state=LOAD, `nib_cnt`=0, `shreg`=0.
- Accept sampled in cycle N: `rx_clr`/`tx_wr` high in cycle N+1 only.
- 8th nibble accepted in cycle N: `imem_we` high in cycle N+2, and `word_count` updated in N+2.
- `run_req` rise sampled in N: `cpu_run`=1 in N+1. If a write is pending, the state change is deferred so that `imem_we` precedes `cpu_run` by ≥1 cycle.
- `rst` mid-word or mid-run: next cycle all outputs are at reset values. Pending strobes are cancelled and the partial word is lost.
- Maximum throughput: one byte per 2 cycles, limited by the lockout.

## Structure

- Package `uart_boot_pkg`:
  - state enum `boot_state_t` {LOAD, RUN, HALTED};
  - ASCII constants (CR, LF, '0', '9', 'A', 'F', 'a', 'f');
  - `NIBBLES_PER_WORD`=8.
- Sub-module `hex_ascii_decode`: combinational; 8-bit in → `{is_hex, nibble[3:0]}`. Instantiated once.
- Top: FSM, nibble shifter/counter, write-pointer and strobe registers.

## Test plan

- Load word:
  - Stimulus: send "00A00193".
  - Response: eight echoes equal to the input; then one `imem_we` with addr 0 and data 0x00A00193; `word_count`=1; `err`=0.
- Case and filler:
  - Stimulus: send "fe0\r\n10ee3".
  - Response: one write of 0xFE010EE3; CR/LF are echoed but produce no nibbles; `err`=0.
- Bad character:
  - Stimulus: send "12G3456789ABCDEF".
  - Response: `err`=1 after 'G'; exactly one write of 0x3456789A; "BCDEF" is left as a partial word (nib_cnt=5).
- Overflow:
  - Stimulus: send 17 words.
  - Response: 16 writes at addr 0..15; the 17th is suppressed; `word_count`=16; `err`=1.
- Run/halt cycle:
  - Stimulus: load 2 words, raise `run_req`, pulse `cpu_halt`, then drop `run_req`.
  - Response: `cpu_run`=1 one cycle after `run_req`; state goes to HALTED with `cpu_run` still 1; after `run_req` drops, `cpu_run`=0, `word_count`=0, and new bytes are echoed again.
- Backpressure and reset:
  - Stimulus: hold `tx_busy`=1 with `rx_valid`=1.
  - Response: no `rx_clr`, no `tx_wr`.
  - Stimulus: assert `rst` after 4 nibbles.
  - Response: all outputs are at reset values the next cycle; a fresh 8 nibbles yields a write at addr 0.

Source files
------------

// File: rtl/uart_boot_pkg.sv
// Shared types and constants for the UART boot sequencer.
package uart_boot_pkg;

    typedef enum logic [1:0] {
        LOAD,
        RUN,
        HALTED
    } boot_state_t;

    localparam logic [7:0] CHAR_CR      = 8'h0D;
    localparam logic [7:0] CHAR_LF      = 8'h0A;
    localparam logic [7:0] CHAR_0       = 8'h30;
    localparam logic [7:0] CHAR_9       = 8'h39;
    localparam logic [7:0] CHAR_UPPER_A = 8'h41;
    localparam logic [7:0] CHAR_UPPER_F = 8'h46;
    localparam logic [7:0] CHAR_LOWER_A = 8'h61;
    localparam logic [7:0] CHAR_LOWER_F = 8'h66;

    localparam int unsigned NIBBLES_PER_WORD = 8;

endpackage

// File: rtl/hex_ascii_decode.sv
// Combinational ASCII hex character to nibble decoder.
module hex_ascii_decode
    import uart_boot_pkg::*;
(
    input  logic [7:0] code,
    output logic       is_hex,
    output logic [3:0] nibble
);

    // Letters carry (value - 9) in their low nibble, e.g. 'A' = 0x41 -> 1 + 9.
    always_comb begin
        is_hex = 1'b0;
        nibble = 4'h0;
        if (code >= CHAR_0 && code <= CHAR_9) begin
            is_hex = 1'b1;
            nibble = code[3:0];
        end else if ((code >= CHAR_UPPER_A && code <= CHAR_UPPER_F) ||
                     (code >= CHAR_LOWER_A && code <= CHAR_LOWER_F)) begin
            is_hex = 1'b1;
            nibble = code[3:0] + 4'd9;
        end
    end

endmodule

// File: rtl/uart_boot_sequencer.sv
// Packs echoed UART hex characters into instruction-memory words, then gates
// the CPU through a LOAD -> RUN -> HALTED sequence.
module uart_boot_sequencer
    import uart_boot_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = $clog2(DEPTH),
    parameter int unsigned WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_clr,
    output logic [7:0]        tx_data,
    output logic              tx_wr,
    input  logic              tx_busy,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    input  logic              run_req,
    input  logic              cpu_halt,
    output logic              cpu_run,
    output logic [ADDR_W:0]   word_count,
    output logic              err
);

    localparam logic [ADDR_W:0] COUNT_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] COUNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [2:0]      LAST_NIB   = 3'(NIBBLES_PER_WORD - 1);

    boot_state_t       state_q, state_d;
    logic [2:0]        nib_cnt_q, nib_cnt_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic              wr_pend_q, wr_pend_d;
    logic              rx_clr_q, rx_clr_d;
    logic              tx_wr_q, tx_wr_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [WORD_W-1:0] imem_wdata_q, imem_wdata_d;
    logic              cpu_run_q, cpu_run_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;
    logic              err_q, err_d;

    logic              accept;
    logic              is_hex;
    logic [3:0]        nibble;

    hex_ascii_decode u_decode (
        .code   (rx_data),
        .is_hex (is_hex),
        .nibble (nibble)
    );

    // The registered rx_clr locks out the byte the UART is still clearing.
    assign accept = rx_valid && !tx_busy && !rx_clr_q;

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        nib_cnt_d    = nib_cnt_q;
        shreg_d      = shreg_q;
        wr_pend_d    = 1'b0;
        rx_clr_d     = 1'b0;
        tx_wr_d      = 1'b0;
        tx_data_d    = tx_data_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        cpu_run_d    = cpu_run_q;
        word_count_d = word_count_q;
        err_d        = err_q;

        unique case (state_q)
            LOAD: begin
                if (accept) begin
                    rx_clr_d  = 1'b1;
                    tx_wr_d   = 1'b1;
                    tx_data_d = rx_data;
                    if (is_hex) begin
                        shreg_d = {shreg_q[WORD_W-5:0], nibble};
                        if (nib_cnt_q == LAST_NIB) begin
                            nib_cnt_d = 3'd0;
                            wr_pend_d = 1'b1;
                        end else begin
                            nib_cnt_d = nib_cnt_q + 3'd1;
                        end
                    end else if (rx_data != CHAR_CR && rx_data != CHAR_LF) begin
                        err_d     = 1'b1;
                        nib_cnt_d = 3'd0;
                    end
                end

                // Word was completed last cycle; shreg now holds it.
                if (wr_pend_q) begin
                    if (word_count_q == COUNT_FULL) begin
                        err_d = 1'b1;
                    end else begin
                        imem_we_d    = 1'b1;
                        imem_addr_d  = word_count_q[ADDR_W-1:0];
                        imem_wdata_d = shreg_q;
                        word_count_d = word_count_q + COUNT_ONE;
                    end
                end

                // Hold off the run until any completed word has been written.
                if (run_req && !wr_pend_q && !wr_pend_d) begin
                    if (nib_cnt_d != 3'd0) begin
                        err_d = 1'b1;
                    end
                    nib_cnt_d = 3'd0;
                    cpu_run_d = 1'b1;
                    state_d   = RUN;
                end
            end

            RUN: begin
                rx_clr_d = accept;
                if (!run_req) begin
                    state_d      = LOAD;
                    cpu_run_d    = 1'b0;
                    word_count_d = '0;
                    nib_cnt_d    = 3'd0;
                end else if (cpu_halt) begin
                    state_d = HALTED;
                end
            end

            HALTED: begin
                rx_clr_d = accept;
                if (!run_req) begin
                    state_d      = LOAD;
                    cpu_run_d    = 1'b0;
                    word_count_d = '0;
                    nib_cnt_d    = 3'd0;
                end
            end

            default: begin
                state_d = LOAD;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= LOAD;
            nib_cnt_q    <= 3'd0;
            shreg_q      <= '0;
            wr_pend_q    <= 1'b0;
            rx_clr_q     <= 1'b0;
            tx_wr_q      <= 1'b0;
            tx_data_q    <= 8'h00;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_run_q    <= 1'b0;
            word_count_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            nib_cnt_q    <= nib_cnt_d;
            shreg_q      <= shreg_d;
            wr_pend_q    <= wr_pend_d;
            rx_clr_q     <= rx_clr_d;
            tx_wr_q      <= tx_wr_d;
            tx_data_q    <= tx_data_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_run_q    <= cpu_run_d;
            word_count_q <= word_count_d;
            err_q        <= err_d;
        end
    end

    assign rx_clr     = rx_clr_q;
    assign tx_wr      = tx_wr_q;
    assign tx_data    = tx_data_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_run    = cpu_run_q;
    assign word_count = word_count_q;
    assign err        = err_q;

endmodule

// File: tb/tb_uart_boot_sequencer.sv
// Directed/randomized bench for uart_boot_sequencer with a string-level model.
module tb_uart_boot_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_clr;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        tx_busy;
    logic        imem_we;
    logic [3:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        run_req;
    logic        cpu_halt;
    logic        cpu_run;
    logic [4:0]  word_count;
    logic        err;

    uart_boot_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_clr     (rx_clr),
        .tx_data    (tx_data),
        .tx_wr      (tx_wr),
        .tx_busy    (tx_busy),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .run_req    (run_req),
        .cpu_halt   (cpu_halt),
        .cpu_run    (cpu_run),
        .word_count (word_count),
        .err        (err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int clr_cyc = 0;
    int we_cyc = 0;
    int gap_max = 2;

    // Reference model: expected writes, word count, partial nibbles, error.
    logic [35:0] exp_q[$];
    logic [35:0] act_q[$];
    logic [31:0] m_part = 32'h0;
    int          m_pn = 0;
    int          m_wc = 0;
    logic        m_err = 1'b0;
    logic        m_running = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every cycle that shows a write strobe.
    always @(negedge clk) begin
        if (imem_we) begin
            act_q.push_back({imem_addr, imem_wdata});
            we_cyc = cyc;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int hexval(input logic [7:0] b);
        if (b >= "0" && b <= "9") return int'(b) - 48;
        if (b >= "A" && b <= "F") return int'(b) - 55;
        if (b >= "a" && b <= "f") return int'(b) - 87;
        return -1;
    endfunction

    function automatic logic [7:0] hexchar(input int v);
        if (v < 10) return 8'(48 + v);
        if ($urandom_range(0, 1) == 1) return 8'(55 + v);
        return 8'(87 + v);
    endfunction

    task automatic model_byte(input logic [7:0] b);
        int v;
        v = hexval(b);
        if (v >= 0) begin
            m_part = (m_part << 4) | 32'(v);
            m_pn++;
            if (m_pn == 8) begin
                m_pn = 0;
                if (m_wc == 16) m_err = 1'b1;
                else begin
                    exp_q.push_back({4'(m_wc), m_part});
                    m_wc++;
                end
            end
        end else if (b != 8'h0D && b != 8'h0A) begin
            m_err = 1'b1;
            m_pn = 0;
        end
    endtask

    task automatic model_run_start();
        if (m_pn != 0) m_err = 1'b1;
        m_pn = 0;
        m_running = 1'b1;
    endtask

    task automatic model_load_enter();
        m_wc = 0;
        m_pn = 0;
        m_running = 1'b0;
    endtask

    task automatic model_reset();
        m_part = 32'h0;
        m_pn = 0;
        m_wc = 0;
        m_err = 1'b0;
        m_running = 1'b0;
        exp_q.delete();
        act_q.delete();
    endtask

    // Present one byte like the UART: pending until rx_clr consumes it.
    task automatic send_byte(input logic [7:0] b);
        int n;
        @(negedge clk);
        rx_data = b;
        rx_valid = 1'b1;
        n = 0;
        while (!rx_clr && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rx_clr latency", 64'(n), 64'd1);
        clr_cyc = cyc;
        check("tx_wr on accept", 64'(tx_wr), 64'(!m_running));
        if (!m_running) begin
            check("echo data", 64'(tx_data), 64'(b));
            model_byte(b);
        end
        rx_valid = 1'b0;
        repeat ($urandom_range(0, gap_max)) @(negedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 7; i >= 0; i--) send_byte(hexchar(int'(w[4*i +: 4])));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_writes(input string tag);
        int n;
        check({tag, " write count"}, 64'(act_q.size()), 64'(exp_q.size()));
        n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, " write addr/data"}, 64'(act_q[i]), 64'(exp_q[i]));
        check({tag, " word_count"}, 64'(word_count), 64'(m_wc));
        check({tag, " err"}, 64'(err), 64'(m_err));
        exp_q.delete();
        act_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " rx_clr"}, 64'(rx_clr), 64'd0);
        check({tag, " tx_wr"}, 64'(tx_wr), 64'd0);
        check({tag, " tx_data"}, 64'(tx_data), 64'd0);
        check({tag, " imem_we"}, 64'(imem_we), 64'd0);
        check({tag, " imem_addr"}, 64'(imem_addr), 64'd0);
        check({tag, " imem_wdata"}, 64'(imem_wdata), 64'd0);
        check({tag, " cpu_run"}, 64'(cpu_run), 64'd0);
        check({tag, " word_count"}, 64'(word_count), 64'd0);
        check({tag, " err"}, 64'(err), 64'd0);
    endtask

    initial begin
        logic [7:0] b;
        rst = 1'b1;
        rx_data = 8'h00;
        rx_valid = 1'b0;
        tx_busy = 1'b0;
        run_req = 1'b0;
        cpu_halt = 1'b0;
        idle(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        idle(2);

        // Load word: one write two cycles after the 8th nibble's accept.
        send_str("00A00193");
        idle(4);
        check("write latency", 64'(we_cyc), 64'(clr_cyc + 1));
        check("load word data", 64'(act_q.size() > 0 ? act_q[0][31:0] : 32'h0), 64'h00A00193);
        check_writes("load word");

        // Mixed case with CR/LF filler in the middle.
        send_str("fe0");
        send_byte(8'h0D);
        send_byte(8'h0A);
        send_str("10ee3");
        idle(4);
        check_writes("case filler");

        // Bad character discards the partial word and sets err.
        send_str("12G");
        check("err after G", 64'(err), 64'd1);
        send_str("3456789ABCDEF");
        idle(4);
        check_writes("bad char");

        // Run/halt cycle.
        send_word($urandom);
        send_word($urandom);
        idle(4);
        check_writes("preload");
        @(negedge clk);
        run_req = 1'b1;
        model_run_start();
        @(negedge clk);
        check("cpu_run after run_req", 64'(cpu_run), 64'd1);
        send_byte(8'(48 + $urandom_range(0, 9)));
        @(negedge clk);
        cpu_halt = 1'b1;
        @(negedge clk);
        cpu_halt = 1'b0;
        idle(2);
        check("cpu_run in halted", 64'(cpu_run), 64'd1);
        send_byte(8'h41);
        idle(2);
        check_writes("run dropped bytes");
        @(negedge clk);
        run_req = 1'b0;
        model_load_enter();
        @(negedge clk);
        check("cpu_run after drop", 64'(cpu_run), 64'd0);
        check("word_count after drop", 64'(word_count), 64'd0);
        send_str("ab");

        // 8th nibble and run_req rise together: write precedes cpu_run.
        while (m_pn != 7) send_byte(hexchar(int'($urandom_range(0, 15))));
        b = hexchar(int'($urandom_range(0, 15)));
        @(negedge clk);
        rx_data = b;
        rx_valid = 1'b1;
        run_req = 1'b1;
        @(negedge clk);
        check("deferred rx_clr", 64'(rx_clr), 64'd1);
        check("deferred echo", 64'(tx_data), 64'(b));
        check("deferred cpu_run n+1", 64'(cpu_run), 64'd0);
        rx_valid = 1'b0;
        model_byte(b);
        @(negedge clk);
        check("deferred imem_we", 64'(imem_we), 64'd1);
        check("deferred cpu_run n+2", 64'(cpu_run), 64'd0);
        @(negedge clk);
        check("deferred cpu_run n+3", 64'(cpu_run), 64'd1);
        model_run_start();
        check_writes("deferred run");
        // run_req fall and cpu_halt rise together in RUN go to LOAD.
        @(negedge clk);
        run_req = 1'b0;
        cpu_halt = 1'b1;
        @(negedge clk);
        cpu_halt = 1'b0;
        model_load_enter();
        check("fall+halt cpu_run", 64'(cpu_run), 64'd0);
        idle(2);
        check("fall+halt stays load", 64'(cpu_run), 64'd0);

        // Overflow: 17 random words, the last one suppressed.
        for (int i = 0; i < 17; i++) send_word($urandom);
        idle(4);
        check_writes("overflow");

        // Backpressure: a held byte is not consumed while tx_busy.
        @(negedge clk);
        tx_busy = 1'b1;
        rx_data = 8'h0A;
        rx_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("busy rx_clr", 64'(rx_clr), 64'd0);
            check("busy tx_wr", 64'(tx_wr), 64'd0);
        end
        tx_busy = 1'b0;
        @(negedge clk);
        check("unbusy rx_clr", 64'(rx_clr), 64'd1);
        check("unbusy echo", 64'(tx_data), 64'h0A);
        rx_valid = 1'b0;
        model_byte(8'h0A);
        idle(2);

        // Reset while a completed word waits to be written.
        gap_max = 0;
        send_word($urandom);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst pending write");
        rst = 1'b0;
        model_reset();
        idle(3);
        check_writes("rst cancelled write");

        // Reset mid-word, then a fresh word lands at address 0.
        gap_max = 2;
        for (int i = 0; i < 4; i++) send_byte(hexchar(int'($urandom_range(0, 15))));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst mid word");
        rst = 1'b0;
        model_reset();
        send_word($urandom);
        idle(4);
        check("fresh write addr", 64'(act_q.size() > 0 ? act_q[0][35:32] : 4'hF), 64'd0);
        check_writes("after reset");

        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
